// File: rtl/majority_voter_pkg.sv
// Shared definitions for the N-channel majority voter: health encodings and
// the popcount-threshold helper used by both the bit voter and the health FSM.
package majority_voter_pkg;

    localparam int unsigned MAX_CH = 7;
    localparam int unsigned FCNT_W = 8;

    typedef enum logic [1:0] {
        HEALTH_OK       = 2'd0,
        HEALTH_DEGRADED = 2'd1,
        HEALTH_FAILED   = 2'd2
    } health_e;

    // True when at least 'thresh' bits of 'bits' are set
    function automatic logic popcount_ge(input logic [MAX_CH-1:0] bits,
                                         input int unsigned       thresh);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < int'(MAX_CH); i++) begin
            cnt += {31'd0, bits[i]};
        end
        return cnt >= thresh;
    endfunction

endpackage

// File: rtl/majority_bit_vote.sv
// Combinational single-bit majority across N_CH channel bits.
module majority_bit_vote
    import majority_voter_pkg::*;
#(
    parameter int unsigned N_CH = 3
) (
    input  logic [N_CH-1:0] bits_i,
    output logic            vote_o
);

    assign vote_o = popcount_ge(MAX_CH'(bits_i), (N_CH + 1) / 2);

endmodule

// File: rtl/majority_voter.sv
// N-channel bitwise majority voter with one registered output stage,
// per-channel consecutive-disagreement fault tracking and a health FSM.
module majority_voter
    import majority_voter_pkg::*;
#(
    parameter int unsigned N_CH         = 3,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned FAULT_THRESH = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic                  clear_faults,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_unanimous,
    output logic [N_CH-1:0]       disagree,
    output logic [N_CH-1:0]       fault,
    output logic [1:0]            health,
    output logic [CNT_W-1:0]      err_cnt
);

    localparam int unsigned        MAJ     = (N_CH + 1) / 2;
    localparam logic [FCNT_W-1:0]  THRESH  = FCNT_W'(FAULT_THRESH);
    localparam logic [CNT_W-1:0]   ERR_MAX = '1;

    logic                accept_c;
    logic [WIDTH-1:0]    voted_c;
    logic [N_CH-1:0]     disagree_c;

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic                unan_q, unan_d;
    logic [N_CH-1:0]     disagree_q, disagree_d;
    logic [N_CH-1:0]     fault_q, fault_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [FCNT_W-1:0]   cnt_q [N_CH];
    logic [FCNT_W-1:0]   cnt_d [N_CH];
    health_e             health_q, health_d;

    assign in_ready = rst_n & (~out_valid_q | out_ready);
    assign accept_c = in_valid & in_ready;

    // One voter per bit column
    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        logic [N_CH-1:0] col;
        for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
            assign col[k] = in_data[k*WIDTH + i];
        end
        majority_bit_vote #(.N_CH(N_CH)) u_vote (
            .bits_i (col),
            .vote_o (voted_c[i])
        );
    end

    always_comb begin
        disagree_c = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            disagree_c[k] = (in_data[k*WIDTH +: WIDTH] != voted_c);
        end
    end

    // Output stage next state
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        unan_d      = unan_q;
        disagree_d  = disagree_q;
        if (accept_c) begin
            out_valid_d = 1'b1;
            out_data_d  = voted_c;
            unan_d      = ~|disagree_c;
            disagree_d  = disagree_c;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Fault counters and error count; clear wins over a same-cycle beat
    always_comb begin
        fault_d = fault_q;
        err_d   = err_q;
        for (int k = 0; k < int'(N_CH); k++) begin
            cnt_d[k] = cnt_q[k];
        end
        if (clear_faults) begin
            fault_d = '0;
            err_d   = '0;
            for (int k = 0; k < int'(N_CH); k++) begin
                cnt_d[k] = '0;
            end
        end else if (accept_c) begin
            for (int k = 0; k < int'(N_CH); k++) begin
                if (!disagree_c[k]) begin
                    cnt_d[k] = '0;
                end else if (cnt_q[k] != THRESH) begin
                    cnt_d[k] = cnt_q[k] + FCNT_W'(1);
                end
                if (cnt_d[k] == THRESH) begin
                    fault_d[k] = 1'b1;
                end
            end
            if ((|disagree_c) && (err_q != ERR_MAX)) begin
                err_d = err_q + CNT_W'(1);
            end
        end
    end

    // Health FSM next state
    always_comb begin
        health_d = health_q;
        if (clear_faults) begin
            health_d = HEALTH_OK;
        end else begin
            case (health_q)
                HEALTH_OK, HEALTH_DEGRADED: begin
                    if (popcount_ge(MAX_CH'(fault_d), MAJ)) begin
                        health_d = HEALTH_FAILED;
                    end else if (|fault_d) begin
                        health_d = HEALTH_DEGRADED;
                    end
                end
                HEALTH_FAILED: health_d = HEALTH_FAILED;
                default:       health_d = HEALTH_OK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            unan_q      <= 1'b0;
            disagree_q  <= '0;
            fault_q     <= '0;
            err_q       <= '0;
            health_q    <= HEALTH_OK;
            for (int k = 0; k < int'(N_CH); k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            unan_q      <= unan_d;
            disagree_q  <= disagree_d;
            fault_q     <= fault_d;
            err_q       <= err_d;
            health_q    <= health_d;
            for (int k = 0; k < int'(N_CH); k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_data      = out_data_q;
    assign out_unanimous = unan_q;
    assign disagree      = disagree_q;
    assign fault         = fault_q;
    assign err_cnt       = err_q;
    assign health        = health_q;

endmodule

// File: tb/tb_majority_voter.sv
// Scoreboard bench for majority_voter: a reference model queues the expected
// held beat on each acceptance; a negedge monitor checks whatever the DUT holds.
module tb_majority_voter;

    localparam int unsigned N_CH  = 3;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned TH    = 4;
    localparam int unsigned CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n, in_valid, in_ready, clear_faults;
    logic                  out_valid, out_ready, out_unanimous;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [WIDTH-1:0]      out_data;
    logic [N_CH-1:0]       disagree, fault;
    logic [1:0]            health;
    logic [CNT_W-1:0]      err_cnt;

    always #5 clk = ~clk;

    majority_voter #(
        .N_CH(N_CH), .WIDTH(WIDTH), .FAULT_THRESH(TH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clear_faults(clear_faults), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_unanimous(out_unanimous),
        .disagree(disagree), .fault(fault), .health(health), .err_cnt(err_cnt)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       unan;
        logic [2:0] dis;
        logic [2:0] flt;
        logic [1:0] hl;
        logic [7:0] err;
    } exp_t;

    exp_t     sb[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       m_cnt [N_CH];
    logic [2:0] m_fault = '0;
    int       m_err = 0;
    bit       m_ov = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] pack3(input logic [7:0] c0, input logic [7:0] c1,
                                          input logic [7:0] c2);
        return {c2, c1, c0};
    endfunction

    // Majority: more than half of the channels hold a one
    function automatic logic [7:0] ref_vote(input logic [23:0] d);
        logic [7:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            int ones;
            ones = 0;
            for (int k = 0; k < int'(N_CH); k++) ones += int'(d[k*8 + b]);
            r[b] = (2 * ones > int'(N_CH));
        end
        return r;
    endfunction

    function automatic logic [1:0] ref_health(input logic [2:0] f);
        int n;
        n = $countones(f);
        if (n >= 2) return 2'd2;
        if (n >= 1) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_step();
        logic [7:0] vt;
        logic [2:0] dis;
        bit         acc;
        if (!rst_n) begin
            m_ov = 1'b0; m_fault = '0; m_err = 0;
            foreach (m_cnt[k]) m_cnt[k] = 0;
            sb.delete();
            return;
        end
        acc = in_valid && (!m_ov || out_ready);
        vt  = ref_vote(in_data);
        for (int k = 0; k < int'(N_CH); k++) dis[k] = (in_data[k*8 +: 8] != vt);
        if (clear_faults) begin
            m_fault = '0; m_err = 0;
            foreach (m_cnt[k]) m_cnt[k] = 0;
        end else if (acc) begin
            for (int k = 0; k < int'(N_CH); k++) begin
                m_cnt[k] = dis[k] ? ((m_cnt[k] < int'(TH)) ? m_cnt[k] + 1 : int'(TH)) : 0;
                if (m_cnt[k] == int'(TH)) m_fault[k] = 1'b1;
            end
            if (dis != 3'b000 && m_err < 255) m_err++;
        end
        if (acc) begin
            m_ov = 1'b1;
            sb.push_back('{vt, (dis == 3'b000), dis, m_fault, ref_health(m_fault), 8'(m_err)});
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic cycle(input bit v, input logic [23:0] d, input bit rdy,
                         input bit clr, input bit rn);
        rst_n = rn; in_valid = v; in_data = d; out_ready = rdy; clear_faults = clr;
        @(posedge clk);
        model_step();
        #2;
    endtask

    // Monitor: checks handshake signals and the held beat against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("in_ready", 32'(in_ready), 32'(rst_n && (!m_ov || out_ready)));
            check("out_valid", 32'(out_valid), 32'(m_ov));
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL sb_empty: got out_valid=1 expected no held beat at %0t", $time);
                end else begin
                    e = sb[0];
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_unanimous", 32'(out_unanimous), 32'(e.unan));
                    check("disagree", 32'(disagree), 32'(e.dis));
                    check("fault", 32'(fault), 32'(e.flt));
                    check("health", 32'(health), 32'(e.hl));
                    check("err_cnt", 32'(err_cnt), 32'(e.err));
                    if (out_ready && rst_n) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        bit v, rdy, clr, rn;
        logic [7:0] base, ch [3];
        foreach (m_cnt[k]) m_cnt[k] = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_faults = 1'b0;
        cycle(0, '0, 0, 0, 0);
        cycle(0, '0, 0, 0, 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_unanimous", 32'(out_unanimous), 0);
        check("rst_disagree", 32'(disagree), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_health", 32'(health), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);

        cycle(1, pack3(8'hF0, 8'hCC, 8'hAA), 1, 0, 1);
        check("vote_e8_data", 32'(out_data), 32'h E8);
        check("vote_e8_unan", 32'(out_unanimous), 0);
        check("vote_e8_dis", 32'(disagree), 32'b111);
        check("vote_e8_err", 32'(err_cnt), 1);

        cycle(1, pack3(8'h5A, 8'h5A, 8'h5A), 1, 0, 1);
        check("unan_data", 32'(out_data), 32'h5A);
        check("unan_flag", 32'(out_unanimous), 1);
        check("unan_dis", 32'(disagree), 0);
        check("unan_err", 32'(err_cnt), 1);

        repeat (3) cycle(1, pack3(8'h3C, 8'h3C, 8'h00), 1, 0, 1);
        cycle(1, pack3(8'h3C, 8'h3C, 8'h3C), 1, 0, 1);
        check("three_no_fault", 32'(fault), 0);
        repeat (3) cycle(1, pack3(8'h3C, 8'h3C, 8'h00), 1, 0, 1);
        check("pre_thresh_fault", 32'(fault), 0);
        cycle(1, pack3(8'h3C, 8'h3C, 8'h00), 1, 0, 1);
        check("thresh_fault", 32'(fault), 32'b100);
        check("thresh_degraded", 32'(health), 1);
        check("thresh_err", 32'(err_cnt), 8);

        cycle(0, '0, 1, 0, 1);
        cycle(1, pack3(8'h11, 8'h22, 8'h33), 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cycle(1, pack3(8'h99, 8'h77, 8'h66), 0, 0, 1);
            check("stall_in_ready", 32'(in_ready), 0);
            check("stall_hold_data", 32'(out_data), 32'h33);
            check("stall_err", 32'(err_cnt), 9);
        end
        in_data = pack3(8'h44, 8'h44, 8'h44); out_ready = 1'b1;
        #1 check("resume_in_ready", 32'(in_ready), 1);
        cycle(1, pack3(8'h44, 8'h44, 8'h44), 1, 0, 1);
        check("resume_data", 32'(out_data), 32'h44);

        repeat (4) cycle(1, pack3(8'h11, 8'hEE, 8'h11), 1, 0, 1);
        check("failed_fault", 32'(fault), 32'b110);
        check("failed_health", 32'(health), 2);
        cycle(1, pack3(8'hF0, 8'hCC, 8'hAA), 1, 1, 1);
        check("clear_fault", 32'(fault), 0);
        check("clear_err", 32'(err_cnt), 0);
        check("clear_health", 32'(health), 0);
        check("clear_still_voted", 32'(out_data), 32'hE8);

        repeat (4) cycle(1, pack3(8'h00, 8'hFF, 8'hFF), 1, 0, 1);
        check("ch0_fault", 32'(fault), 32'b001);
        cycle(1, pack3(8'h12, 8'h12, 8'h12), 0, 0, 1);
        rst_n = 1'b0;
        #1 check("rst_in_ready", 32'(in_ready), 0);
        cycle(1, pack3(8'h12, 8'h12, 8'h12), 0, 0, 0);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_fault", 32'(fault), 0);
        check("midrst_health", 32'(health), 0);
        cycle(0, '0, 1, 0, 1);

        repeat (260) cycle(1, pack3(8'hF0, 8'hCC, 8'hAA), 1, 0, 1);
        check("err_saturate", 32'(err_cnt), 255);

        for (int i = 0; i < 3000; i++) begin
            v    = ($urandom_range(3) != 0);
            rdy  = ($urandom_range(9) < 7);
            rn   = ($urandom_range(399) != 0);
            base = 8'($urandom);
            for (int k = 0; k < 3; k++) begin
                ch[k] = base;
                if ($urandom_range(3) == 0) ch[k] = base ^ 8'($urandom);
            end
            if ($urandom_range(7) == 0) ch[2] = 8'($urandom);
            clr = rn && v && (!m_ov || rdy) && ($urandom_range(199) == 0);
            cycle(v, pack3(ch[0], ch[1], ch[2]), rdy, clr, rn);
        end

        cycle(0, '0, 1, 0, 1);
        cycle(0, '0, 1, 0, 1);
        check("drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/majority_voter.md
MAJORITY_VOTER -- requirements
Module: majority_voter

Interface
REQ-001 Parameter N_CH, default 3, number of voted channels; SHALL be odd, 3..7.
REQ-002 Parameter WIDTH, default 8, bits per channel word.
REQ-003 Parameter FAULT_THRESH, default 4, consecutive disagreeing beats that latch a channel fault; range 1..255.
REQ-004 Parameter CNT_W, default 8, width of the saturating error counter.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 in_valid  input  1  input beat offered.
REQ-008 in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-009 in_data  input  N_CH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-010 clear_faults  input  1  one-cycle pulse clearing fault state and counters.
REQ-011 out_valid  output  1  voted word available.
REQ-012 out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-013 out_data  output  WIDTH  bitwise majority word.
REQ-014 out_unanimous  output  1  all channels equal for the held beat.
REQ-015 disagree  output  N_CH  per channel: word != out_data for the held beat.
REQ-016 fault  output  N_CH  sticky per-channel fault flags.
REQ-017 health  output  2  0=OK, 1=DEGRADED, 2=FAILED.
REQ-018 err_cnt  output  CNT_W  saturating count of accepted beats with at least one disagreeing channel.

Function
REQ-019 Voted bit i SHALL be 1 iff at least (N_CH+1)/2 channels have bit i = 1.
REQ-020 Output SHALL be a single registered stage; out_data, out_unanimous and disagree load on the cycle after acceptance (latency 1).
REQ-021 in_ready SHALL equal (!out_valid || out_ready) while rst_n is high, and 0 while rst_n is low.
REQ-022 out_valid SHALL set on acceptance and clear on output handshake without a new acceptance; simultaneous handshake and acceptance keeps it 1 with new data.
REQ-023 Held outputs SHALL remain stable while out_valid && !out_ready.
REQ-024 Each channel SHALL have a consecutive-disagreement counter: +1 on an accepted beat where the channel disagrees, cleared to 0 on an accepted beat where it agrees, unchanged on cycles without acceptance; saturates at FAULT_THRESH.
REQ-025 fault[k] SHALL set on the cycle after the counter reaches FAULT_THRESH and stay set until clear_faults or reset.
REQ-026 err_cnt SHALL increment per accepted beat with any disagreement and saturate at 2^CNT_W-1.
REQ-027 health SHALL be a registered state machine: OK while no faults; OK->DEGRADED when 1..(N_CH-1)/2 faults are set; any->FAILED when faults >= (N_CH+1)/2; FAILED sticky until clear_faults; clear_faults returns to OK.
REQ-028 clear_faults SHALL take priority over a same-cycle accepted beat: counters, faults and err_cnt go to 0 and that beat is not counted, though it is still voted and output.
REQ-029 Fault state SHALL never gate voting; faulted channels still vote.

Reset
REQ-030 With rst_n low at a clock edge: out_valid=0, out_data=0, out_unanimous=0, disagree=0, fault=0, health=OK, err_cnt=0, all channel counters 0.
REQ-031 Reset asserted mid-transfer SHALL discard the held beat without an output handshake.

Structure
REQ-032 Shared package SHALL hold health encodings (HEALTH_OK, HEALTH_DEGRADED, HEALTH_FAILED) and the popcount-threshold helper function.
REQ-033 One sub-module majority_bit_vote (N_CH inputs, 1 output, combinational) SHALL be instantiated WIDTH times; counters and FSM stay in the top.

Verification (N_CH=3, WIDTH=8, FAULT_THRESH=4)
REQ-034 in_data ch0..2 = 0xF0,0xCC,0xAA, out_ready=1 -> next cycle out_data=0xE8, out_unanimous=0, disagree=3'b111, err_cnt=1.
REQ-035 ch0..2 = 0x5A each -> out_data=0x5A, out_unanimous=1, disagree=0, err_cnt unchanged.
REQ-036 ch0,ch1=0x3C, ch2=0x00 for 4 accepted beats -> fault[2]=1 and health=DEGRADED the cycle after the 4th; with only 3 such beats followed by an agreeing beat -> fault stays 0.
REQ-037 out_ready=0 for 3 cycles with out_valid=1 -> out_data held, in_ready=0, counters unchanged; out_ready=1 -> next beat accepted same cycle.
REQ-038 Faults on ch1 and ch2 -> health=FAILED; clear_faults pulsed alongside a disagreeing beat -> fault=0, err_cnt=0, health=OK.
REQ-039 rst_n low for one edge while out_valid=1 -> out_valid=0, fault=0, in_ready=0 during reset.
